// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// fetch FSM state type and instruction-stream constants.
package fetch_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus. The fetch stage is the master;
// the instruction memory is the slave. At most one request is outstanding.
interface fetch_if #(
    parameter int unsigned XLEN = fetch_pkg::XLEN,
    parameter int unsigned ILEN = fetch_pkg::ILEN
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register with load / hold / clear controls.
// clear drops the valid bit only (bubble); PC and instruction keep their
// last values. clear takes priority over load.
module ifid_reg #(
    parameter int unsigned XLEN = fetch_pkg::XLEN,
    parameter int unsigned ILEN = fetch_pkg::ILEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_d,
    input  logic [ILEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_q,
    output logic [ILEN-1:0] instr_q,
    output logic            valid_q
);

    // Pipeline register: clear beats load, otherwise hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the next PC back to Program_Counter,
// issues single-outstanding fetches to instruction memory, and loads the
// IF/ID register. Handles hazard stalls and EX branch redirects, including
// discarding a fetch that is still in flight when the redirect arrives.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = fetch_pkg::XLEN,
    parameter int unsigned ILEN = fetch_pkg::ILEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_Out,
    output logic [XLEN-1:0] PC_In,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    fetch_if.master         imem,
    output logic [XLEN-1:0] IFID_PC,
    output logic [ILEN-1:0] IFID_Instr,
    output logic            IFID_Valid
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] req_pc;
    logic [ILEN-1:0] hold_instr;
    logic            deliver;
    logic [ILEN-1:0] deliver_instr;
    logic            ifid_clear;

    // Request only from REQ, never alongside a redirect or while in reset
    always_comb begin
        imem.imem_req  = reset && (state == REQ) && !branch_taken;
        imem.imem_addr = PC_Out & ALIGN_MASK;
    end

    // Next state, next PC and IF/ID delivery decision
    always_comb begin
        state_nxt     = state;
        PC_In         = PC_Out;
        deliver       = 1'b0;
        deliver_instr = imem.imem_rdata;
        case (state)
            REQ: begin
                if (!branch_taken && imem.imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    // Same-cycle rvalid is simply dropped; otherwise the
                    // response is still owed and must be absorbed in DROP.
                    state_nxt = imem.imem_rvalid ? REQ : DROP;
                end else if (imem.imem_rvalid) begin
                    if (stall) begin
                        state_nxt = HOLD;
                    end else begin
                        deliver   = 1'b1;
                        PC_In     = req_pc + STEP;
                        state_nxt = REQ;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    state_nxt = REQ;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr;
                    PC_In         = PC_Out + STEP;
                    state_nxt     = REQ;
                end
            end
            DROP: begin
                if (imem.imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
        if (branch_taken) begin
            PC_In = branch_target & ALIGN_MASK;
        end
    end

    // Bubble whenever the pipe advances without a new instruction
    always_comb begin
        ifid_clear = branch_taken || (!stall && !deliver);
    end

    // Fetch FSM with request-PC latch and stall hold buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= REQ;
            req_pc     <= '0;
            hold_instr <= '0;
        end else begin
            state <= state_nxt;
            if (state == REQ && state_nxt == WAIT) begin
                req_pc <= PC_Out;
            end
            if (state == WAIT && state_nxt == HOLD) begin
                hold_instr <= imem.imem_rdata;
            end
        end
    end

    ifid_reg #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .load    (deliver),
        .clear   (ifid_clear),
        .pc_d    (req_pc),
        .instr_d (deliver_instr),
        .pc_q    (IFID_PC),
        .instr_q (IFID_Instr),
        .valid_q (IFID_Valid)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 64-bit pipelined core. It sits between Program_Counter and the ID stage.
- Consumes the registered PC (PC_Out) and computes the next PC (PC_In) fed back to Program_Counter.
- Issues requests to instruction memory and loads the IF/ID pipeline register.
- Handles hazard-unit stalls and EX-stage branch redirects, including discarding in-flight fetches.

Parameters:
- XLEN, 64, address/PC width
- ILEN, 32, instruction width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- PC_Out  in  XLEN  current PC from Program_Counter
- PC_In  out  XLEN  next PC to Program_Counter; Program_Counter loads it every clock
- stall  in  1  hazard unit: hold IF/ID and PC
- branch_taken  in  1  EX redirect strobe, one cycle
- branch_target  in  XLEN  redirect address
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (>=1 cycle after gnt)
- imem_rdata  in  ILEN  fetched instruction
- IFID_PC  out  XLEN  PC of instruction in IF/ID
- IFID_Instr  out  ILEN  instruction in IF/ID
- IFID_Valid  out  1  IF/ID holds a real instruction

Behaviour:
- At most one outstanding imem request.
- imem_addr = PC_Out, with bits [1:0] forced to 0.
- Default PC_In = PC_Out (hold). Because Program_Counter updates every edge, every non-advance cycle must drive PC_Out.
- branch_taken has top priority:
  - PC_In = {branch_target[XLEN-1:2], 2'b00}.
  - IFID_Valid <= 0 at the next edge, regardless of stall.
  - imem_req is forced 0 that cycle.
- FSM states: REQ, WAIT, HOLD, DROP. Reset state: REQ.
- REQ:
  - imem_req = 1 (unless branch_taken).
  - If imem_gnt: latch req_pc <= PC_Out, go to WAIT.
- WAIT:
  - imem_req = 0; imem_gnt is ignored.
  - On imem_rvalid with !stall: IFID_Instr <= imem_rdata, IFID_PC <= req_pc, IFID_Valid <= 1; PC_In = req_pc + 4; go to REQ.
  - On imem_rvalid with stall: latch data into the hold buffer; go to HOLD.
  - On branch_taken without rvalid: go to DROP.
  - On branch_taken with rvalid in the same cycle: discard the data; go to REQ.
- HOLD:
  - Buffer is valid; imem_req = 0.
  - When !stall: load IF/ID from the buffer; PC_In = PC_Out + 4; go to REQ.
  - On branch_taken: discard the buffer; go to REQ.
- DROP:
  - imem_req = 0.
  - On imem_rvalid: discard the data; go to REQ.
  - A further branch_taken updates PC_In and stays in DROP.
- IF/ID register rules:
  - stall = 1 and no branch: all IFID_* outputs hold.
  - stall = 0 and no instruction delivered this cycle: IFID_Valid <= 0 (bubble). IFID_PC and IFID_Instr hold.
- PC arithmetic: +4 is modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
- Reset (reset = 0, asynchronous):
  - State becomes REQ; hold buffer is cleared.
  - IFID_PC = 0, IFID_Instr = 0, IFID_Valid = 0.
  - imem_req is forced 0 while reset is asserted.
  - Reset mid-WAIT abandons the request. The memory side is reset by the same signal, so no stale rvalid is expected.
- Latency: from grant, the instruction appears in IF/ID at the edge after rvalid. Peak throughput is one instruction per two cycles plus memory latency.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN/ILEN defaults
  - fetch_state_t enum {REQ, WAIT, HOLD, DROP}
  - INSTR_BYTES = 4
  - NOP_INSTR = 32'h0000_0013
- One natural sub-module: ifid_reg. It is the IF/ID pipeline register with load/hold/clear controls and async active-low reset, reusable for later stage registers.
- FSM and next-PC logic stay in fetch_stage.

Test Plan:
- Reset release with PC_Out = 0:
  - memory grants immediately and returns rvalid one cycle later with 0x00500093.
  - Required: imem_addr = 0, then IFID_PC = 0, IFID_Instr = 0x00500093, IFID_Valid = 1, PC_In = 4.
- Stall in WAIT:
  - rvalid arrives with stall = 1 for 3 cycles.
  - Required: state HOLD, IFID_* unchanged, PC_In = PC_Out.
  - After stall drops: IF/ID loads the buffered instruction and PC_In = PC_Out + 4.
- branch_taken in WAIT, target 0x1002 (rvalid two cycles later):
  - Required: PC_In = 0x1000, IFID_Valid = 0, state DROP.
  - The late rdata is discarded; the next imem_addr = 0x1000.
- branch_taken together with rvalid in WAIT:
  - Required: data discarded, IFID_Valid = 0, state REQ, PC_In = branch target.
- PC_Out = 0xFFFF_FFFF_FFFF_FFFC, fetch completes:
  - Required: PC_In = 0.
- reset asserted while in HOLD:
  - Required: IFID_Valid = 0 and imem_req = 0 immediately, asynchronously.
  - After release: state REQ and imem_req = 1.
